tt_um_jleugeri_ttt_multi_core: RTL and testbench
================================================

# tt_um_jleugeri_ttt_multi_core

Time-multiplexed token-threshold neuron core, successor to the single-stream processor core. NUM_PROCESSORS neurons share one two-stage pipeline and one clock, with saturating token counters, a valid/ready programming port that works outside reset, per-neuron mode bits (retrigger, auto-rearm) and a tick-enable instead of a second clock. It sits between the token router (input stream) and the token output encoder (event stream).

## Interface
- NUM_PROCESSORS, 10: neuron count; ID_BITS = $clog2(NUM_PROCESSORS)
- NEW_TOKENS_BITS, 4: signed width of incoming token deltas
- TOKENS_BITS, 8: signed counter width; thresholds are TOKENS_BITS-1 bits unsigned
- DURATION_BITS, 8: token duration counter width
- PROG_WIDTH, 8: programming data width (must be ≥ max(TOKENS_BITS-1, DURATION_BITS, 2))
- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- tick  in  1  slow time-base pulse, one cycle wide
- in_valid  in  1  input token delta present; always accepted
- in_id  in  ID_BITS  target neuron
- in_good, in_bad  in  NEW_TOKENS_BITS each  signed deltas
- out_valid  out  1  one evaluated visit
- out_id  out  ID_BITS  neuron evaluated
- out_event  out  2  10 start, 01 stop, 11 extend, 00 none
- prog_valid  in  1  programming request
- prog_ready  out  1  = reset_n & !in_valid (combinational)
- prog_id  in  ID_BITS; prog_field  in  2 (00 duration, 01 good threshold, 10 bad threshold, 11 mode); prog_data  in  PROG_WIDTH

## Operation
- Per neuron: good_thr, bad_thr, duration, mode[1:0], good, bad (signed), remaining, is_on, tick_pending.
- Reset (reset_n=0 at edge): all per-neuron state and pipeline registers to 0; out_valid=0, out_id=0, out_event=00.
- Stage 1 (in_valid, in_id < NUM_PROCESSORS): good += sext(in_good), bad += sext(in_bad), saturating to [-2^(T-1), 2^(T-1)-1]; register id. in_id ≥ NUM_PROCESSORS: dropped, no output.
- Stage 2 (registered id), priority order:
  - !is_on & good≥0 & bad≤0: is_on=1, remaining=duration, event 10.
  - is_on & (bad>0 | remaining==0): is_on=0, remaining=0, event 01; if mode[1] (rearm) good=-good_thr, bad=-bad_thr.
  - is_on & mode[0] (retrigger) & good≥0: remaining=duration, event 11.
  - else: if is_on & tick_pending: remaining-=1, tick_pending cleared; event 00.
- tick sets tick_pending for every neuron; a tick coinciding with a consume leaves the flag set.
- Programming handshake on prog_valid & prog_ready: field written; threshold write also loads counter with -data[T-2:0]; mode takes data[1:0]. Same-cycle rearm and programming of the same counter: programming wins. Unused high bits ignored.
- duration=0: start on one visit, stop on the next visit.

## Timing
- Input accepted at edge k; counters updated at k; out_valid/out_id/out_event registered at edge k+1 (latency 2 edges from presentation).
- Back-to-back same id: stage 2 at k+1 sees counters written at k; no stall, no bubble.
- Throughput 1 input/cycle; programming only in input-idle cycles.
- reset_n low mid-stream: pipeline flushed; out_valid=0 from the next edge until 2 edges after first post-reset input.

## Structure
- Package ttt_pkg: prog_field_t enum, event_t enum (NONE, STOP, START, EXTEND), mode bit indices.
- Sub-module ttt_sat_add: parametrised signed saturating adder (counter + sign-extended delta), instanced twice.

## Test plan
- Program n3 good_thr=2, bad_thr=1, duration=3; inputs good=+1, +1 -> event 00, then 10 on the second visit.
- n3 on, 3 ticks interleaved with 4 zero-delta visits -> remaining 3→0, fourth visit event 01.
- n3 on, in_bad=+2 -> 01 immediately; with mode=10 counters read back -2/-1 and restart needs fresh tokens.
- mode=01, on with remaining=1, further good token -> event 11, remaining reloaded to 3.
- good counter at 126, delta +7 repeatedly -> holds 127; at -128, delta -8 -> holds -128.
- prog_valid with in_valid high -> prog_ready=0, no write; reset_n low mid-stream -> out_valid 0 next edge, all events 00.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types for the time-multiplexed token-threshold neuron core.
package ttt_pkg;

  // Which per-neuron parameter a programming beat writes.
  typedef enum logic [1:0] {
    FIELD_DURATION = 2'b00,
    FIELD_GOOD_THR = 2'b01,
    FIELD_BAD_THR  = 2'b10,
    FIELD_MODE     = 2'b11
  } prog_field_t;

  // Event code emitted for each evaluated visit.
  typedef enum logic [1:0] {
    EV_NONE   = 2'b00,
    EV_STOP   = 2'b01,
    EV_START  = 2'b10,
    EV_EXTEND = 2'b11
  } event_t;

  // Bit positions inside a neuron's mode register.
  localparam int MODE_RETRIGGER = 0;
  localparam int MODE_REARM     = 1;

endpackage

// File: rtl/ttt_if.sv
// Token input, event output and programming port of the neuron core.
interface ttt_if
  import ttt_pkg::*;
#(
  parameter int ID_BITS         = 4,
  parameter int NEW_TOKENS_BITS = 4,
  parameter int PROG_WIDTH      = 8
) ();

  logic                              in_valid;
  logic [ID_BITS-1:0]                in_id;
  logic signed [NEW_TOKENS_BITS-1:0] in_good;
  logic signed [NEW_TOKENS_BITS-1:0] in_bad;

  logic                              out_valid;
  logic [ID_BITS-1:0]                out_id;
  logic [1:0]                        out_event;

  logic                              prog_valid;
  logic                              prog_ready;
  logic [ID_BITS-1:0]                prog_id;
  prog_field_t                       prog_field;
  logic [PROG_WIDTH-1:0]             prog_data;

  // Upstream side: router/host feeding tokens and configuration.
  modport master (
    output in_valid, in_id, in_good, in_bad,
    output prog_valid, prog_id, prog_field, prog_data,
    input  out_valid, out_id, out_event, prog_ready
  );

  // Core side.
  modport slave (
    input  in_valid, in_id, in_good, in_bad,
    input  prog_valid, prog_id, prog_field, prog_data,
    output out_valid, out_id, out_event, prog_ready
  );

endinterface

// File: rtl/ttt_sat_add.sv
// Signed saturating adder: accumulator plus sign-extended narrower delta.
module ttt_sat_add #(
  parameter int WIDTH       = 8,
  parameter int DELTA_WIDTH = 4
) (
  input  logic signed [WIDTH-1:0]       acc,
  input  logic signed [DELTA_WIDTH-1:0] delta,
  output logic signed [WIDTH-1:0]       sum
);

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] wide_s;

  // One guard bit detects overflow; clamp toward the overflow direction.
  always_comb begin
    wide_s = {acc[WIDTH-1], acc} + {{(WIDTH+1-DELTA_WIDTH){delta[DELTA_WIDTH-1]}}, delta};
    sum    = wide_s[WIDTH-1:0];
    if (wide_s[WIDTH] != wide_s[WIDTH-1]) begin
      sum = wide_s[WIDTH] ? MIN_VAL : MAX_VAL;
    end else begin
      sum = wide_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/tt_um_jleugeri_ttt_multi_core.sv
// Time-multiplexed token-threshold neuron core: stage 1 accumulates token
// deltas into per-neuron counters, stage 2 evaluates the visited neuron and
// emits start/stop/extend events. One neuron visit per cycle, no stalls.
module tt_um_jleugeri_ttt_multi_core
  import ttt_pkg::*;
#(
  parameter int NUM_PROCESSORS  = 10,
  parameter int NEW_TOKENS_BITS = 4,
  parameter int TOKENS_BITS     = 8,
  parameter int DURATION_BITS   = 8,
  parameter int PROG_WIDTH      = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tick,
  ttt_if.slave bus
);

  localparam int ID_BITS = $clog2(NUM_PROCESSORS);
  localparam logic [DURATION_BITS-1:0] DUR_ONE  = {{(DURATION_BITS-1){1'b0}}, 1'b1};
  localparam logic [DURATION_BITS-1:0] DUR_ZERO = {DURATION_BITS{1'b0}};
  localparam logic [ID_BITS-1:0]       ID_ZERO  = {ID_BITS{1'b0}};
  localparam logic [NUM_PROCESSORS-1:0] SEL_ZERO = {NUM_PROCESSORS{1'b0}};

  // A threshold is stored unsigned; the counter is armed at its negation.
  function automatic logic signed [TOKENS_BITS-1:0] neg_thr(input logic [TOKENS_BITS-2:0] thr);
    return -$signed({1'b0, thr});
  endfunction

  // Per-neuron configuration and state.
  logic [TOKENS_BITS-2:0]         good_thr_r   [NUM_PROCESSORS];
  logic [TOKENS_BITS-2:0]         bad_thr_r    [NUM_PROCESSORS];
  logic [DURATION_BITS-1:0]       duration_r   [NUM_PROCESSORS];
  logic [1:0]                     mode_r       [NUM_PROCESSORS];
  logic signed [TOKENS_BITS-1:0]  good_r       [NUM_PROCESSORS];
  logic signed [TOKENS_BITS-1:0]  bad_r        [NUM_PROCESSORS];
  logic [DURATION_BITS-1:0]       remaining_r  [NUM_PROCESSORS];
  logic [NUM_PROCESSORS-1:0]      is_on_r;
  logic [NUM_PROCESSORS-1:0]      tick_pending_r;

  // Pipeline and output registers.
  logic               s1_valid_r;
  logic [ID_BITS-1:0] s1_id_r;
  logic               out_valid_r;
  logic [ID_BITS-1:0] out_id_r;
  event_t             out_event_r;

  // Combinational helpers.
  logic                          prog_ready_s;
  logic                          prog_fire_s;
  logic                          in_hit_s;
  logic [ID_BITS-1:0]            in_idx_s;
  logic signed [TOKENS_BITS-1:0] base_good_s;
  logic signed [TOKENS_BITS-1:0] base_bad_s;
  logic signed [TOKENS_BITS-1:0] sum_good_s;
  logic signed [TOKENS_BITS-1:0] sum_bad_s;
  logic [NUM_PROCESSORS-1:0]     prog_sel_s;
  logic [NUM_PROCESSORS-1:0]     in_sel_s;
  logic [NUM_PROCESSORS-1:0]     s2_sel_s;
  event_t                        ev_s;
  logic                          dec_s;
  logic                          rearm_s;
  logic                          cur_on_s;
  logic                          cur_pending_s;
  logic [1:0]                    cur_mode_s;
  logic signed [TOKENS_BITS-1:0] cur_good_s;
  logic signed [TOKENS_BITS-1:0] cur_bad_s;
  logic [DURATION_BITS-1:0]      cur_rem_s;

  // Programming only slips into cycles with no token on the input.
  assign prog_ready_s   = reset_n & ~bus.in_valid;
  assign prog_fire_s    = bus.prog_valid & prog_ready_s;
  assign bus.prog_ready = prog_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_id     = out_id_r;
  assign bus.out_event  = out_event_r;

  // Qualify the incoming token; out-of-range ids are dropped silently.
  always_comb begin
    in_hit_s = bus.in_valid & (bus.in_id < ID_BITS'(NUM_PROCESSORS));
    in_idx_s = ID_ZERO;
    if (in_hit_s) begin
      in_idx_s = bus.in_id;
    end else begin
      in_idx_s = ID_ZERO;
    end
  end

  // Stage-2 evaluation of the neuron visited by the previous input.
  always_comb begin
    cur_on_s      = is_on_r[s1_id_r];
    cur_pending_s = tick_pending_r[s1_id_r];
    cur_mode_s    = mode_r[s1_id_r];
    cur_good_s    = good_r[s1_id_r];
    cur_bad_s     = bad_r[s1_id_r];
    cur_rem_s     = remaining_r[s1_id_r];
    ev_s          = EV_NONE;
    dec_s         = 1'b0;
    rearm_s       = 1'b0;
    if (!s1_valid_r) begin
      ev_s = EV_NONE;
    end else if (!cur_on_s && !cur_good_s[TOKENS_BITS-1] &&
                 (cur_bad_s[TOKENS_BITS-1] || cur_bad_s == {TOKENS_BITS{1'b0}})) begin
      ev_s = EV_START;
    end else if (cur_on_s && ((!cur_bad_s[TOKENS_BITS-1] && cur_bad_s != {TOKENS_BITS{1'b0}}) ||
                              cur_rem_s == DUR_ZERO)) begin
      ev_s    = EV_STOP;
      rearm_s = cur_mode_s[MODE_REARM];
    end else if (cur_on_s && cur_mode_s[MODE_RETRIGGER] && !cur_good_s[TOKENS_BITS-1]) begin
      ev_s = EV_EXTEND;
    end else begin
      ev_s  = EV_NONE;
      dec_s = cur_on_s & cur_pending_s;
    end
  end

  // A rearm landing on the neuron stage 1 is updating feeds the adder directly.
  always_comb begin
    base_good_s = good_r[in_idx_s];
    base_bad_s  = bad_r[in_idx_s];
    if (rearm_s && (s1_id_r == in_idx_s)) begin
      base_good_s = neg_thr(good_thr_r[in_idx_s]);
      base_bad_s  = neg_thr(bad_thr_r[in_idx_s]);
    end else begin
      base_good_s = good_r[in_idx_s];
      base_bad_s  = bad_r[in_idx_s];
    end
  end

  ttt_sat_add #(.WIDTH(TOKENS_BITS), .DELTA_WIDTH(NEW_TOKENS_BITS)) u_sat_good (
    .acc   (base_good_s),
    .delta (bus.in_good),
    .sum   (sum_good_s)
  );

  ttt_sat_add #(.WIDTH(TOKENS_BITS), .DELTA_WIDTH(NEW_TOKENS_BITS)) u_sat_bad (
    .acc   (base_bad_s),
    .delta (bus.in_bad),
    .sum   (sum_bad_s)
  );

  // Decode which neuron each of the three update sources targets this cycle.
  always_comb begin
    prog_sel_s = SEL_ZERO;
    in_sel_s   = SEL_ZERO;
    s2_sel_s   = SEL_ZERO;
    for (int i = 0; i < NUM_PROCESSORS; i++) begin
      prog_sel_s[i] = prog_fire_s & (bus.prog_id == ID_BITS'(i));
      in_sel_s[i]   = in_hit_s & (in_idx_s == ID_BITS'(i));
      s2_sel_s[i]   = s1_valid_r & (s1_id_r == ID_BITS'(i));
    end
  end

  // Configuration registers written by the programming port.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_PROCESSORS; i++) begin
      if (!reset_n) begin
        good_thr_r[i] <= {(TOKENS_BITS-1){1'b0}};
        bad_thr_r[i]  <= {(TOKENS_BITS-1){1'b0}};
        duration_r[i] <= DUR_ZERO;
        mode_r[i]     <= 2'b00;
      end else if (prog_sel_s[i]) begin
        case (bus.prog_field)
          FIELD_DURATION: duration_r[i] <= bus.prog_data[DURATION_BITS-1:0];
          FIELD_GOOD_THR: good_thr_r[i] <= bus.prog_data[TOKENS_BITS-2:0];
          FIELD_BAD_THR:  bad_thr_r[i]  <= bus.prog_data[TOKENS_BITS-2:0];
          FIELD_MODE:     mode_r[i]     <= bus.prog_data[1:0];
          default:        mode_r[i]     <= mode_r[i];
        endcase
      end
    end
  end

  // Token counters: programming beats accumulation, accumulation beats rearm.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_PROCESSORS; i++) begin
      if (!reset_n) begin
        good_r[i] <= {TOKENS_BITS{1'b0}};
        bad_r[i]  <= {TOKENS_BITS{1'b0}};
      end else begin
        if (prog_sel_s[i] && bus.prog_field == FIELD_GOOD_THR) begin
          good_r[i] <= neg_thr(bus.prog_data[TOKENS_BITS-2:0]);
        end else if (in_sel_s[i]) begin
          good_r[i] <= sum_good_s;
        end else if (s2_sel_s[i] && rearm_s) begin
          good_r[i] <= neg_thr(good_thr_r[i]);
        end
        if (prog_sel_s[i] && bus.prog_field == FIELD_BAD_THR) begin
          bad_r[i] <= neg_thr(bus.prog_data[TOKENS_BITS-2:0]);
        end else if (in_sel_s[i]) begin
          bad_r[i] <= sum_bad_s;
        end else if (s2_sel_s[i] && rearm_s) begin
          bad_r[i] <= neg_thr(bad_thr_r[i]);
        end
      end
    end
  end

  // On/off state, remaining duration and pending tick per neuron.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_PROCESSORS; i++) begin
      if (!reset_n) begin
        is_on_r[i]        <= 1'b0;
        remaining_r[i]    <= DUR_ZERO;
        tick_pending_r[i] <= 1'b0;
      end else begin
        tick_pending_r[i] <= tick | (tick_pending_r[i] & ~(s2_sel_s[i] & dec_s));
        if (s2_sel_s[i]) begin
          case (ev_s)
            EV_START: begin
              is_on_r[i]     <= 1'b1;
              remaining_r[i] <= duration_r[i];
            end
            EV_STOP: begin
              is_on_r[i]     <= 1'b0;
              remaining_r[i] <= DUR_ZERO;
            end
            EV_EXTEND: remaining_r[i] <= duration_r[i];
            default: begin
              if (dec_s) begin
                remaining_r[i] <= remaining_r[i] - DUR_ONE;
              end
            end
          endcase
        end
      end
    end
  end

  // Pipeline id register and registered event outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_r  <= 1'b0;
      s1_id_r     <= ID_ZERO;
      out_valid_r <= 1'b0;
      out_id_r    <= ID_ZERO;
      out_event_r <= EV_NONE;
    end else begin
      s1_valid_r <= in_hit_s;
      if (in_hit_s) begin
        s1_id_r <= in_idx_s;
      end
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_id_r <= s1_id_r;
      end
      out_event_r <= ev_s;
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_multi_core.sv
// Directed table-driven bench for the multi-neuron token-threshold core.
module tb_tt_um_jleugeri_ttt_multi_core;
  import ttt_pkg::*;

  localparam logic [1:0] OP_VISIT = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_TICK  = 2'd2;

  typedef struct {
    logic [1:0] op;
    logic [3:0] id;
    int         a;      // good delta, or programming field
    int         b;      // bad delta, or programming data
    logic       xv;     // expected out_valid (visits only)
    logic [1:0] xe;     // expected out_event when valid
    logic       cc;     // check counters
    int         eg;
    int         eb;
    logic       cr;     // check remaining
    int         er;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  ttt_if #(.ID_BITS(4), .NEW_TOKENS_BITS(4), .PROG_WIDTH(8)) bus ();

  tt_um_jleugeri_ttt_multi_core dut (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] id, input int a, input int b,
                              input logic xv, input logic [1:0] xe, input logic cc, input int eg,
                              input int eb, input logic cr, input int er);
    vec_t v;
    v.op = op; v.id = id; v.a = a; v.b = b; v.xv = xv; v.xe = xe;
    v.cc = cc; v.eg = eg; v.eb = eb; v.cr = cr; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present one token for one cycle, then idle until its result is registered.
  task automatic visit(input logic [3:0] id, input int g, input int b);
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_id = id; bus.in_good = 4'(g); bus.in_bad = 4'(b);
    @(negedge clock);
    bus.in_valid = 1'b0; bus.in_good = 4'sd0; bus.in_bad = 4'sd0;
    @(negedge clock);
  endtask

  task automatic prog(input logic [3:0] id, input int field, input int data);
    @(negedge clock);
    bus.prog_valid = 1'b1; bus.prog_id = id;
    bus.prog_field = prog_field_t'(field[1:0]); bus.prog_data = 8'(data);
    @(negedge clock);
    bus.prog_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clock);
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
  endtask

  initial begin
    vec_t v;
    bus.in_valid = 1'b0; bus.in_id = 4'd0; bus.in_good = 4'sd0; bus.in_bad = 4'sd0;
    bus.prog_valid = 1'b0; bus.prog_id = 4'd0; bus.prog_field = FIELD_DURATION; bus.prog_data = 8'd0;

    // op, id, a, b, xv, xe, cc, eg, eb, cr, er
    tbl.push_back(mk(OP_PROG,  4'd3, 0, 3, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_PROG,  4'd3, 1, 2, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_PROG,  4'd3, 2, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, 1, 0, 1, 2'b00, 1, -1, -1, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, 1, 0, 1, 2'b10, 0, 0, 0, 1, 3));
    tbl.push_back(mk(OP_TICK,  4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, 0, 0, 1, 2'b00, 0, 0, 0, 1, 2));
    tbl.push_back(mk(OP_TICK,  4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, 0, 0, 1, 2'b00, 0, 0, 0, 1, 1));
    tbl.push_back(mk(OP_TICK,  4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, 0, 0, 1, 2'b00, 0, 0, 0, 1, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_PROG,  4'd3, 3, 2, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, 0, 0, 1, 2'b10, 0, 0, 0, 1, 3));
    tbl.push_back(mk(OP_VISIT, 4'd3, 0, 2, 1, 2'b01, 1, -2, -1, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, 1, 0, 1, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, 1, 0, 1, 2'b10, 0, 0, 0, 1, 3));
    tbl.push_back(mk(OP_PROG,  4'd3, 3, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_TICK,  4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, -1, 0, 1, 2'b00, 0, 0, 0, 1, 2));
    tbl.push_back(mk(OP_TICK,  4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd3, 0, 0, 1, 2'b00, 0, 0, 0, 1, 1));
    tbl.push_back(mk(OP_VISIT, 4'd3, 1, 0, 1, 2'b11, 0, 0, 0, 1, 3));
    tbl.push_back(mk(OP_VISIT, 4'd12, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_VISIT, 4'd0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0));

    // Reset state.
    repeat (3) @(negedge clock);
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset out_id", int'(bus.out_id), 0);
    check("reset out_event", int'(bus.out_event), 0);
    check("reset prog_ready", int'(bus.prog_ready), 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle prog_ready", int'(bus.prog_ready), 1);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      case (v.op)
        OP_PROG: prog(v.id, v.a, v.b);
        OP_TICK: pulse_tick();
        default: begin
          visit(v.id, v.a, v.b);
          check($sformatf("row%0d out_valid", i), int'(bus.out_valid), int'(v.xv));
          if (v.xv) begin
            check($sformatf("row%0d out_id", i), int'(bus.out_id), int'(v.id));
            check($sformatf("row%0d out_event", i), int'(bus.out_event), int'(v.xe));
          end
          if (v.cc) begin
            check($sformatf("row%0d good", i), int'($signed(dut.good_r[v.id])), v.eg);
            check($sformatf("row%0d bad", i), int'($signed(dut.bad_r[v.id])), v.eb);
          end
          if (v.cr) begin
            check($sformatf("row%0d remaining", i), int'(dut.remaining_r[v.id]), v.er);
          end
        end
      endcase
    end

    // Positive saturation on neuron 5: 18 x +7 = 126, then clamps at 127.
    for (int i = 0; i < 18; i++) visit(4'd5, 7, 0);
    check("sat good 126", int'($signed(dut.good_r[5])), 126);
    for (int i = 0; i < 2; i++) begin
      visit(4'd5, 7, 0);
      check($sformatf("sat good hold127 #%0d", i), int'($signed(dut.good_r[5])), 127);
    end

    // Negative saturation on neuron 6: 16 x -8 = -128, then holds.
    for (int i = 0; i < 16; i++) visit(4'd6, -8, 0);
    check("sat good -128", int'($signed(dut.good_r[6])), -128);
    for (int i = 0; i < 2; i++) begin
      visit(4'd6, -8, 0);
      check($sformatf("sat good hold-128 #%0d", i), int'($signed(dut.good_r[6])), -128);
    end

    // Back-to-back visits of neuron 7 with zero duration: start then stop.
    prog(4'd7, 1, 1);
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_id = 4'd7; bus.in_good = 4'sd1; bus.in_bad = 4'sd0;
    @(negedge clock);
    bus.in_good = 4'sd0;
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("b2b first valid", int'(bus.out_valid), 1);
    check("b2b first event", int'(bus.out_event), 2);
    @(negedge clock);
    check("b2b second valid", int'(bus.out_valid), 1);
    check("b2b second event", int'(bus.out_event), 1);
    @(negedge clock);
    check("b2b drained", int'(bus.out_valid), 0);

    // Programming is refused while a token is presented.
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_id = 4'd12;
    bus.prog_valid = 1'b1; bus.prog_id = 4'd3; bus.prog_field = FIELD_DURATION; bus.prog_data = 8'd9;
    #1;
    check("busy prog_ready", int'(bus.prog_ready), 0);
    @(negedge clock);
    bus.in_valid = 1'b0; bus.prog_valid = 1'b0;
    @(negedge clock);
    check("busy no write", int'(dut.duration_r[3]), 3);

    // Reset in the middle of a stream flushes the pipeline.
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_id = 4'd7; bus.in_good = 4'sd0; bus.in_bad = 4'sd0;
    @(negedge clock);
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check($sformatf("rst out_valid #%0d", i), int'(bus.out_valid), 0);
      check($sformatf("rst out_event #%0d", i), int'(bus.out_event), 0);
    end
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("post-rst latency 1", int'(bus.out_valid), 0);
    @(negedge clock);
    check("post-rst latency 2", int'(bus.out_valid), 1);
    check("post-rst event", int'(bus.out_event), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
